// File: rtl/fdc_pkg.sv
// Shared types and bit positions for the FDC sector staging buffer.
package fdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST_RD,
    FDC_RD,
    FDC_WR,
    HOST_WR,
    WAIT_ACK
  } fdc_state_t;

  localparam int SR_RDREQ = 31;
  localparam int SR_WRREQ = 30;
  localparam int SR_DRIVE = 25;
  localparam int SR_SIDE  = 24;

  localparam int CR_ACK = 31;
  localparam int CR_ERR = 30;

endpackage

// File: rtl/fdc_sector_ram.sv
// Simple dual-port sector RAM: one write port, one registered read port with enable.
module fdc_sector_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fdc_sector_buffer.sv
// Stages one FDC sector between the nec765 core and the host disk-image side
// through a sector RAM, with a status word announcing each request to the host.
module fdc_sector_buffer
  import fdc_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_write,
  input  logic        req_drive,
  input  logic        req_side,
  input  logic [7:0]  req_track,
  input  logic [7:0]  req_sector,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        fdc_rd,
  output logic [7:0]  fdc_rdata,
  input  logic        fdc_wr,
  input  logic [7:0]  fdc_wdata,
  output logic [31:0] disk_sr,
  input  logic [31:0] disk_cr,
  input  logic [7:0]  disk_data_in,
  input  logic        disk_data_clkin,
  output logic [7:0]  disk_data_out,
  input  logic        disk_data_clkout
);

  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(SECTOR_BYTES - 1);

  fdc_state_t      state_reg, state_next;
  logic [ADDR_W:0] ptr_reg, ptr_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            drive_reg, side_reg;
  logic [7:0]      track_reg, sector_reg;
  logic            clkin_prev_reg, clkout_prev_reg;
  logic            fdc_show_reg;
  logic [7:0]      fdc_hold_reg;

  logic       accept, fdc_take;
  logic       ram_we, ram_re;
  logic [7:0] ram_wdata, ram_rdata;
  logic       clkin_rise, clkout_rise, ptr_last;
  logic       unused_cr;

  assign clkin_rise  = disk_data_clkin & ~clkin_prev_reg;
  assign clkout_rise = disk_data_clkout & ~clkout_prev_reg;
  assign ptr_last    = (ptr_reg == PTR_LAST);
  assign unused_cr   = &{1'b0, disk_cr[29:0]};

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    accept     = 1'b0;
    fdc_take   = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_wdata  = fdc_wdata;
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b1;
      err_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            accept     = 1'b1;
            err_next   = 1'b0;
            state_next = req_write ? FDC_WR : HOST_RD;
          end
        end
        HOST_RD: begin
          if (disk_cr[CR_ERR]) begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = IDLE;
          end else if (clkin_rise) begin
            ram_we    = 1'b1;
            ram_wdata = disk_data_in;
            ptr_next  = ptr_reg + 1'b1;
            if (ptr_last) state_next = FDC_RD;
          end
        end
        FDC_RD: begin
          if (fdc_rd) begin
            fdc_take = 1'b1;
            ram_re   = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            if (ptr_last) begin
              done_next  = 1'b1;
              err_next   = 1'b0;
              state_next = IDLE;
            end
          end
        end
        FDC_WR: begin
          if (fdc_wr) begin
            ram_we   = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            if (ptr_last) state_next = HOST_WR;
          end
        end
        HOST_WR: begin
          // Read port streams buf[ptr] continuously so the host sees it settle.
          ram_re = 1'b1;
          if (disk_cr[CR_ERR]) begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = IDLE;
          end else if (clkout_rise) begin
            ptr_next = ptr_reg + 1'b1;
            if (ptr_last) state_next = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (disk_cr[CR_ACK]) begin
            done_next  = 1'b1;
            err_next   = disk_cr[CR_ERR];
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (state_next != state_reg) ptr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      drive_reg       <= 1'b0;
      side_reg        <= 1'b0;
      track_reg       <= '0;
      sector_reg      <= '0;
      clkin_prev_reg  <= 1'b1;
      clkout_prev_reg <= 1'b1;
      fdc_show_reg    <= 1'b0;
      fdc_hold_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      clkin_prev_reg  <= disk_data_clkin;
      clkout_prev_reg <= disk_data_clkout;
      fdc_show_reg    <= fdc_take;
      if (fdc_show_reg) fdc_hold_reg <= ram_rdata;
      if (accept) begin
        drive_reg  <= req_drive;
        side_reg   <= req_side;
        track_reg  <= req_track;
        sector_reg <= req_sector;
      end
    end
  end

  fdc_sector_ram #(
    .DEPTH (SECTOR_BYTES),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ptr_reg[ADDR_W-1:0]),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ptr_reg[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  always_comb begin
    disk_sr = '0;
    if (state_reg != IDLE) begin
      disk_sr[SR_RDREQ] = (state_reg == HOST_RD);
      disk_sr[SR_WRREQ] = (state_reg == HOST_WR) || (state_reg == WAIT_ACK);
      disk_sr[SR_DRIVE] = drive_reg;
      disk_sr[SR_SIDE]  = side_reg;
      disk_sr[23:16]    = track_reg;
      disk_sr[15:8]     = sector_reg;
    end
  end

  // RAM output goes straight out the cycle after a read, then the copy holds it.
  assign fdc_rdata     = fdc_show_reg ? ram_rdata : fdc_hold_reg;
  assign disk_data_out = (state_reg == HOST_WR) ? ram_rdata : 8'h00;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_fdc_sector_buffer.sv
// Bench for fdc_sector_buffer: full read/write sectors against a byte-array model,
// a vector table of request words, and hand-written abort/reset/strobe corner cases.
module tb_fdc_sector_buffer;

  logic        clk = 1'b0;
  logic        rst, req, req_write, req_drive, req_side, abort;
  logic [7:0]  req_track, req_sector;
  logic        busy, done, err;
  logic        fdc_rd, fdc_wr;
  logic [7:0]  fdc_rdata, fdc_wdata;
  logic [31:0] disk_sr, disk_cr;
  logic [7:0]  disk_data_in, disk_data_out;
  logic        disk_data_clkin, disk_data_clkout;

  int tests = 0;
  int fails = 0;
  int hold_bad = 0;
  logic [7:0] model [512];

  always #5 clk = ~clk;

  fdc_sector_buffer dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_drive(req_drive),
    .req_side(req_side), .req_track(req_track), .req_sector(req_sector), .abort(abort),
    .busy(busy), .done(done), .err(err), .fdc_rd(fdc_rd), .fdc_rdata(fdc_rdata),
    .fdc_wr(fdc_wr), .fdc_wdata(fdc_wdata), .disk_sr(disk_sr), .disk_cr(disk_cr),
    .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
    .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout)
  );

  typedef struct {
    bit          w;
    bit          d;
    bit          s;
    logic [7:0]  t;
    logic [7:0]  sec;
    logic [31:0] sr;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [31:0] exp_sr(bit rdq, bit wrq, bit d, bit s, logic [7:0] t, logic [7:0] sec);
    return {rdq, wrq, 4'b0000, d, s, t, sec, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  task automatic gap(input int maxg);
    repeat ($urandom_range(maxg, 0)) tick();
  endtask

  task automatic start(input bit w, input bit d, input bit s, input logic [7:0] t, input logic [7:0] sec);
    req = 1'b1; req_write = w; req_drive = d; req_side = s; req_track = t; req_sector = sec;
    tick();
    req = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] b);
    disk_data_in = b; disk_data_clkin = 1'b1;
    tick();
    disk_data_clkin = 1'b0;
    tick();
  endtask

  task automatic fdc_pull(output logic [7:0] b, output logic dn, output logic er);
    fdc_rd = 1'b1;
    tick();
    fdc_rd = 1'b0;
    b = fdc_rdata; dn = done; er = err;
    tick();
    if (fdc_rdata !== b) hold_bad++;
  endtask

  task automatic fdc_push(input logic [7:0] b);
    fdc_wdata = b; fdc_wr = 1'b1;
    tick();
    fdc_wr = 1'b0;
    tick();
  endtask

  task automatic host_pull(output logic [7:0] b);
    b = disk_data_out; disk_data_clkout = 1'b1;
    tick();
    disk_data_clkout = 1'b0;
    tick();
  endtask

  task automatic read_op(input bit d, input bit s, input logic [7:0] t, input logic [7:0] sec,
                         input int gmax, input string tag);
    logic [7:0] b;
    logic dn, er, last_dn, last_er;
    int bad = 0;
    start(1'b0, d, s, t, sec);
    chk({tag, "_sr_host_rd"}, disk_sr, exp_sr(1, 0, d, s, t, sec));
    for (int i = 0; i < 512; i++) begin
      host_push(model[i]);
      gap(gmax);
    end
    chk({tag, "_sr_fdc_rd"}, disk_sr, exp_sr(0, 0, d, s, t, sec));
    hold_bad = 0;
    last_dn = 1'b0; last_er = 1'b1;
    for (int i = 0; i < 512; i++) begin
      fdc_pull(b, dn, er);
      if (b !== model[i]) bad++;
      if (i < 511 && dn) bad++;
      last_dn = dn; last_er = er;
      gap(gmax);
    end
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_hold_bad"}, hold_bad, 0);
    chk({tag, "_done"}, last_dn, 1);
    chk({tag, "_err"}, last_er, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic write_op(input bit d, input bit s, input logic [7:0] t, input logic [7:0] sec,
                          input int gmax, input bit ack_err, input string tag);
    logic [7:0] b;
    int bad = 0;
    start(1'b1, d, s, t, sec);
    chk({tag, "_sr_fdc_wr"}, disk_sr, exp_sr(0, 0, d, s, t, sec));
    for (int i = 0; i < 512; i++) begin
      fdc_push(model[i]);
      gap(gmax);
    end
    chk({tag, "_sr_host_wr"}, disk_sr, exp_sr(0, 1, d, s, t, sec));
    for (int i = 0; i < 512; i++) begin
      host_pull(b);
      if (b !== model[i]) bad++;
      gap(gmax);
    end
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_sr_wait_ack"}, disk_sr, exp_sr(0, 1, d, s, t, sec));
    chk({tag, "_busy_wait_ack"}, busy, 1);
    disk_cr = {1'b1, ack_err, 30'd0};
    tick();
    disk_cr = '0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, ack_err);
    chk({tag, "_busy_end"}, busy, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic dn, er;
    logic [7:0] rt, rs;
    bit rd_d, rd_s, ae;

    vecs[0] = '{w: 0, d: 1, s: 1, t: 8'h50, sec: 8'h09, sr: 32'h83500900};
    vecs[1] = '{w: 1, d: 0, s: 1, t: 8'hFF, sec: 8'h01, sr: 32'h01FF0100};
    vecs[2] = '{w: 0, d: 0, s: 0, t: 8'h00, sec: 8'h00, sr: 32'h80000000};
    vecs[3] = '{w: 1, d: 1, s: 0, t: 8'h12, sec: 8'hAB, sr: 32'h0212AB00};

    rst = 1'b1; req = 0; req_write = 0; req_drive = 0; req_side = 0; req_track = 0; req_sector = 0;
    abort = 0; fdc_rd = 0; fdc_wr = 0; fdc_wdata = 0; disk_cr = 0; disk_data_in = 0;
    disk_data_clkin = 0; disk_data_clkout = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fdc_rdata", fdc_rdata, 0);
    chk("rst_disk_sr", disk_sr, 0);
    chk("rst_disk_data_out", disk_data_out, 0);

    // Directed read: host bytes i^0x5A, request word 0x8127C500.
    for (int i = 0; i < 512; i++) model[i] = 8'(i) ^ 8'h5A;
    read_op(1'b0, 1'b1, 8'h27, 8'hC5, 0, "rd1");

    // Directed write: FDC bytes i[7:0], request word 0x42034100 while host reads.
    for (int i = 0; i < 512; i++) model[i] = 8'(i);
    write_op(1'b1, 1'b0, 8'h03, 8'h41, 0, 1'b0, "wr1");

    // Randomized read and write with random gaps and fields.
    for (int i = 0; i < 512; i++) model[i] = 8'($urandom);
    rd_d = 1'($urandom); rd_s = 1'($urandom); rt = 8'($urandom); rs = 8'($urandom);
    read_op(rd_d, rd_s, rt, rs, 2, "rd_rand");
    for (int i = 0; i < 512; i++) model[i] = 8'($urandom);
    ae = 1'($urandom);
    write_op(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1, ae, "wr_rand");

    // Host error after 100 bytes.
    start(1'b0, 1'b0, 1'b0, 8'h10, 8'h01);
    chk("herr_err_cleared_on_req", err, 0);
    for (int i = 0; i < 100; i++) host_push(8'(i));
    disk_cr = 32'h40000000;
    tick();
    disk_cr = '0;
    chk("herr_done", done, 1);
    chk("herr_err", err, 1);
    chk("herr_sr", disk_sr, 0);
    chk("herr_busy", busy, 0);
    tick();
    chk("herr_err_holds", err, 1);
    chk("herr_done_pulse", done, 0);

    // Strobe robustness: long clkin, stray fdc_rd, req while busy.
    for (int i = 0; i < 512; i++) model[i] = 8'(i) ^ 8'h33;
    model[0] = 8'hA5;
    start(1'b0, 1'b1, 1'b0, 8'h44, 8'h07);
    disk_data_in = 8'hA5; disk_data_clkin = 1'b1;
    repeat (5) tick();
    disk_data_clkin = 1'b0;
    tick();
    fdc_rd = 1'b1; tick(); fdc_rd = 1'b0; tick();
    start(1'b1, 1'b0, 1'b1, 8'h99, 8'h88);
    chk("strb_sr_req_busy", disk_sr, exp_sr(1, 0, 1, 0, 8'h44, 8'h07));
    for (int i = 1; i < 512; i++) host_push(model[i]);
    chk("strb_sr_fdc_rd", disk_sr, exp_sr(0, 0, 1, 0, 8'h44, 8'h07));
    begin
      int bad = 0;
      for (int i = 0; i < 512; i++) begin
        fdc_pull(b, dn, er);
        if (b !== model[i]) bad++;
      end
      chk("strb_data_bad", bad, 0);
      chk("strb_done", dn, 1);
    end

    // Abort in FDC_RD at byte 300, then new read restarts at byte 0.
    for (int i = 0; i < 512; i++) model[i] = 8'($urandom);
    start(1'b0, 1'b0, 1'b0, 8'h05, 8'h02);
    for (int i = 0; i < 512; i++) host_push(model[i]);
    for (int i = 0; i < 300; i++) fdc_pull(b, dn, er);
    chk("abort_byte299", b, model[299]);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sr", disk_sr, 0);
    for (int i = 0; i < 512; i++) model[i] = 8'($urandom);
    start(1'b0, 1'b1, 1'b1, 8'h06, 8'h03);
    for (int i = 0; i < 512; i++) host_push(model[i]);
    fdc_pull(b, dn, er);
    chk("abort_restart_byte0", b, model[0]);
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // Reset in HOST_WR; later clkout edges do nothing.
    start(1'b1, 1'b1, 1'b1, 8'h22, 8'h33);
    for (int i = 0; i < 512; i++) fdc_push(8'(i + 1));
    for (int i = 0; i < 3; i++) host_pull(b);
    chk("rstwr_busy_before", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstwr_busy", busy, 0);
    chk("rstwr_done", done, 0);
    chk("rstwr_err", err, 0);
    chk("rstwr_sr", disk_sr, 0);
    chk("rstwr_dout", disk_data_out, 0);
    chk("rstwr_fdc_rdata", fdc_rdata, 0);
    for (int i = 0; i < 4; i++) host_pull(b);
    chk("rstwr_post_busy", busy, 0);
    chk("rstwr_post_sr", disk_sr, 0);
    chk("rstwr_post_dout", disk_data_out, 0);

    // Table of request words; each entry is aborted right after acceptance.
    for (int k = 0; k < 4; k++) begin
      start(vecs[k].w, vecs[k].d, vecs[k].s, vecs[k].t, vecs[k].sec);
      chk($sformatf("vec%0d_sr", k), disk_sr, vecs[k].sr);
      chk($sformatf("vec%0d_busy", k), busy, 1);
      chk($sformatf("vec%0d_err_clear", k), err, 0);
      abort = 1'b1; tick(); abort = 1'b0;
      chk($sformatf("vec%0d_abort_done", k), done, 1);
      chk($sformatf("vec%0d_abort_sr", k), disk_sr, 0);
    end

    // req together with abort in IDLE: no operation starts.
    tick();
    req = 1'b1; req_write = 1'b0; abort = 1'b1;
    tick();
    req = 1'b0; abort = 1'b0;
    chk("reqabort_busy", busy, 0);
    chk("reqabort_done", done, 1);
    chk("reqabort_sr", disk_sr, 0);
    tick();
    chk("reqabort_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
